// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: parametrised serial bit-pattern detector built from a history
// shift register and a fill counter, with a registered match copy and saturating match counter.
module seq_pattern_detector #(
    parameter int unsigned       PAT_W   = 6,
    parameter logic [PAT_W-1:0]  PATTERN = 6'b110101,
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             d_in,
    input  logic             overlap_en,
    input  logic             clear_cnt,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned      FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-2:0]  hist;
    logic [PAT_W-2:0]  hist_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic [PAT_W-1:0]  window;
    logic              full;
    logic [CNT_W-1:0]  cnt_next;
    logic              sat_next;

    // Detection path: the incoming bit completes the window when PAT_W-1 valid bits precede it.
    // NOTE: every always_comb target gets a default first, so no latch can be inferred.
    always_comb begin
        window    = {hist, d_in};
        full      = (fill == FILL_FULL);
        match     = en & ~reset & full & (window == PATTERN);
        hist_next = hist;
        fill_next = fill;
        if (en) begin
            hist_next = window[PAT_W-2:0];
            if (match && !overlap_en) begin
                fill_next = '0;
            end else if (!full) begin
                fill_next = fill + 1'b1;
            end
        end
    end

    // Saturating match counter; clear wins over a coincident match.
    always_comb begin
        cnt_next = match_cnt;
        sat_next = cnt_sat;
        if (clear_cnt) begin
            cnt_next = '0;
            sat_next = 1'b0;
        end else if (match && (match_cnt != CNT_MAX)) begin
            cnt_next = match_cnt + 1'b1;
            if (match_cnt == CNT_MAX - 1'b1) begin
                sat_next = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist      <= '0;
            fill      <= '0;
            match_q   <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            hist      <= hist_next;
            fill      <= fill_next;
            match_q   <= match;
            match_cnt <= cnt_next;
            cnt_sat   <= sat_next;
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: scoreboard bench for seq_pattern_detector (pattern 110101),
// with a second CNT_W=2 instance for counter saturation and clear.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       reset, en, d_in, overlap_en, clear_cnt;
    logic       match, match_q, cnt_sat;
    logic [7:0] match_cnt;
    logic       match2, match_q2, cnt_sat2;
    logic [1:0] match_cnt2;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_m_q[$];

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(6), .PATTERN(6'b110101), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .d_in(d_in), .overlap_en(overlap_en),
        .clear_cnt(clear_cnt), .match(match), .match_q(match_q),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_pattern_detector #(.PAT_W(6), .PATTERN(6'b110101), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .d_in(d_in), .overlap_en(overlap_en),
        .clear_cnt(clear_cnt), .match(match2), .match_q(match_q2),
        .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    // Drive one cycle of stimulus on the falling edge and queue its expected match.
    task automatic drive(input logic r, input logic e, input logic b, input logic clr,
                         input logic exp_m);
        @(negedge clk);
        reset     = r;
        en        = e;
        d_in      = b;
        clear_cnt = clr;
        exp_m_q.push_back(exp_m);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; d_in = 1'b0; clear_cnt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic want;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            want = exp_m_q.pop_front();
            n_cmp++;
            if (match !== want) begin
                n_bad++; $display("FAIL reset_match cyc %0d: got %b want %b", i, match, want);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (match_q !== 1'b0) begin
                n_bad++; $display("FAIL reset_match_q cyc %0d: got %b want 0", i, match_q);
            end
            n_cmp++;
            if (match_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
                n_bad++; $display("FAIL reset_cnt cyc %0d: got %0d/%b want 0/0", i, match_cnt, cnt_sat);
            end
        end
    endtask

    task automatic test_overlap(input logic ov, input logic [10:0] exp_v, input int exp_cnt);
        logic [10:0] bits = 11'b11010110101;
        logic        want;
        do_reset();
        overlap_en = ov;
        for (int i = 10; i >= 0; i--) begin
            drive(1'b0, 1'b1, bits[i], 1'b0, exp_v[i]);
            want = exp_m_q.pop_front();
            n_cmp++;
            if (match !== want) begin
                n_bad++; $display("FAIL ov%0b_match bit %0d: got %b want %b", ov, 11 - i, match, want);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (match_q !== want) begin
                n_bad++; $display("FAIL ov%0b_match_q bit %0d: got %b want %b", ov, 11 - i, match_q, want);
            end
        end
        n_cmp++;
        if (match_cnt !== 8'(exp_cnt)) begin
            n_bad++; $display("FAIL ov%0b_cnt: got %0d want %0d", ov, match_cnt, exp_cnt);
        end
    endtask

    task automatic test_enable_gap();
        logic [8:0] ens  = 9'b111000111;
        logic [8:0] bits = 9'b110101101;
        logic [8:0] exp_v = 9'b000000001;
        logic       want;
        do_reset();
        overlap_en = 1'b1;
        for (int i = 8; i >= 0; i--) begin
            drive(1'b0, ens[i], bits[i], 1'b0, exp_v[i]);
            want = exp_m_q.pop_front();
            n_cmp++;
            if (match !== want) begin
                n_bad++; $display("FAIL gap_match step %0d: got %b want %b", 9 - i, match, want);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (match_cnt !== 8'd1 || match_q !== 1'b1) begin
            n_bad++; $display("FAIL gap_cnt: got %0d/%b want 1/1", match_cnt, match_q);
        end
    endtask

    task automatic test_mid_reset();
        logic [12:0] rs    = 13'b0000100000000;
        logic [12:0] ens   = 13'b1111011111111;
        logic [12:0] bits  = 13'b1101001110101;
        logic [12:0] exp_v = 13'b0000000000001;
        logic        want;
        do_reset();
        overlap_en = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            drive(rs[i], ens[i], bits[i], 1'b0, exp_v[i]);
            want = exp_m_q.pop_front();
            n_cmp++;
            if (match !== want) begin
                n_bad++; $display("FAIL midrst_match step %0d: got %b want %b", 13 - i, match, want);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (match_cnt !== 8'd1) begin
            n_bad++; $display("FAIL midrst_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [5:0] head = 6'b110101;
        logic [4:0] tail = 5'b10101;
        logic [1:0] cnt2_tab[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        logic       sat2_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] cnt_tab[5]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
        logic [1:0] exp_c2 = 2'd0;
        logic       exp_s2 = 1'b0;
        logic [7:0] exp_c  = 8'd0;
        logic       b, want, is_m;
        int         k = 0;
        do_reset();
        overlap_en = 1'b1;
        for (int i = 0; i < 26; i++) begin
            b    = (i < 6) ? head[5 - i] : tail[4 - ((i - 6) % 5)];
            is_m = (i == 5) || (i > 5 && ((i - 6) % 5) == 4);
            drive(1'b0, 1'b1, b, (i == 25), is_m);
            want = exp_m_q.pop_front();
            n_cmp++;
            if (match2 !== want) begin
                n_bad++; $display("FAIL sat_match bit %0d: got %b want %b", i + 1, match2, want);
            end
            @(posedge clk); #1;
            if (is_m) begin
                exp_c2 = cnt2_tab[k]; exp_s2 = sat2_tab[k]; exp_c = cnt_tab[k];
                k++;
            end
            n_cmp++;
            if (match_cnt2 !== exp_c2 || cnt_sat2 !== exp_s2) begin
                n_bad++; $display("FAIL sat_cnt2 bit %0d: got %0d/%b want %0d/%b",
                                  i + 1, match_cnt2, cnt_sat2, exp_c2, exp_s2);
            end
            n_cmp++;
            if (match_cnt !== exp_c || cnt_sat !== 1'b0) begin
                n_bad++; $display("FAIL sat_cnt8 bit %0d: got %0d/%b want %0d/0",
                                  i + 1, match_cnt, cnt_sat, exp_c);
            end
        end
        clear_cnt = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; d_in = 1'b1; overlap_en = 1'b1; clear_cnt = 1'b0;
        test_reset();
        test_overlap(1'b1, 11'b00000100001, 2);
        test_overlap(1'b0, 11'b00000100000, 1);
        test_enable_gap();
        test_mid_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
